// File: rtl/fx_math_pkg.sv
// ============================================================================
// Module      : fx_math_pkg
// Description : Shared fixed-point math helpers and iterative-unit FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fx_math_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } sqrt_state_t;

    // Radicand width: magnitude bits plus fractional shift, rounded up to even.
    function automatic int calc_rw(input int width, input int frac);
        int raw;
        raw = width - 1 + frac;
        return raw + (raw % 2);
    endfunction

    function automatic int calc_n(input int width, input int frac);
        return calc_rw(width, frac) / 2;
    endfunction

    function automatic int calc_iter(input int n, input int bpc);
        return (n + bpc - 1) / bpc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fx_sqrt_iter_if.sv
// ============================================================================
// Module      : fx_sqrt_iter_if
// Description : Valid/ready request and response bundle of the square-root unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fx_sqrt_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] result_out;
    logic [WIDTH:0]   rem_out;
    logic             err_out;
    logic             valid_out;
    logic             ready_in;

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, result_out, rem_out, err_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, result_out, rem_out, err_out, valid_out
    );
endinterface

`default_nettype wire

// File: rtl/sqrt_step.sv
// ============================================================================
// Module      : sqrt_step
// Description : One restoring digit-recurrence step of the integer square root.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_step #(
    parameter int N = 21
) (
    input  wire  [N+1:0] rem_cur,
    input  wire  [N-1:0] root_cur,
    input  wire  [1:0]   pair,
    output logic [N+1:0] rem_next,
    output logic [N-1:0] root_next
);
    logic [N+3:0] shifted;
    logic [N+3:0] trial;

    // Trial subtract of (4*root + 1); a negative result restores the shifted remainder.
    assign shifted   = {rem_cur, pair};
    assign trial     = shifted - {2'b00, root_cur, 2'b01};
    assign rem_next  = trial[N+3] ? shifted[N+1:0] : trial[N+1:0];
    assign root_next = {root_cur[N-2:0], ~trial[N+3]};
endmodule

`default_nettype wire

// File: rtl/fx_sqrt_iter.sv
// ============================================================================
// Module      : fx_sqrt_iter
// Description : Iterative signed fixed-point square root, BPC root bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx_sqrt_iter
    import fx_math_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 11,
    parameter int BPC       = 1,
    parameter int ROUND     = 0
) (
    input  wire             clk_in,
    input  wire             rst_in,
    fx_sqrt_iter_if.slave   bus
);
    localparam int N     = calc_n(WIDTH, FRAC_BITS);
    localparam int ITER  = calc_iter(N, BPC);
    // Radicand register is padded so every cycle consumes a full BPC digit group.
    localparam int RP    = 2 * BPC * ITER;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int REM_W = WIDTH + 1;
    localparam logic [N-1:0] ROOT_MAX = '1;

    sqrt_state_t      state;
    logic [RP-1:0]    rad;
    logic [N-1:0]     root;
    logic [N+1:0]     part_rem;
    logic [CNT_W-1:0] iter_cnt;
    logic             neg_in;

    logic [N+1:0]     rem_chain  [0:BPC];
    logic [N-1:0]     root_chain [0:BPC];
    logic             accept;
    logic             round_up;
    logic [N-1:0]     root_fin;

    assign bus.ready_out = (state == IDLE) || ((state == DONE) && bus.ready_in);
    assign accept        = bus.valid_in && bus.ready_out;

    assign round_up = (ROUND != 0) && ({2'b00, root} < part_rem) && (root != ROOT_MAX);
    assign root_fin = round_up ? root + N'(1) : root;

    assign rem_chain[0]  = part_rem;
    assign root_chain[0] = root;

    generate
        for (genvar i = 0; i < BPC; i++) begin : g_step
            sqrt_step #(
                .N (N)
            ) u_step (
                .rem_cur   (rem_chain[i]),
                .root_cur  (root_chain[i]),
                .pair      (rad[RP-1-2*i -: 2]),
                .rem_next  (rem_chain[i+1]),
                .root_next (root_chain[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            rad            <= '0;
            root           <= '0;
            part_rem       <= '0;
            iter_cnt       <= '0;
            neg_in         <= 1'b0;
            bus.result_out <= '0;
            bus.rem_out    <= '0;
            bus.err_out    <= 1'b0;
            bus.valid_out  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && bus.ready_in) begin
                        bus.valid_out <= 1'b0;
                        state         <= IDLE;
                    end
                    if (accept) begin
                        bus.valid_out <= 1'b0;
                        iter_cnt      <= '0;
                        root          <= '0;
                        part_rem      <= '0;
                        rad           <= RP'(bus.data_in[WIDTH-2:0]) << FRAC_BITS;
                        neg_in        <= bus.data_in[WIDTH-1];
                        state         <= bus.data_in[WIDTH-1] ? FINAL : CALC;
                    end
                end
                CALC: begin
                    rad      <= rad << (2 * BPC);
                    root     <= root_chain[BPC];
                    part_rem <= rem_chain[BPC];
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == CNT_W'(ITER - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    if (neg_in) begin
                        bus.result_out <= '0;
                        bus.rem_out    <= '0;
                        bus.err_out    <= 1'b1;
                    end else begin
                        bus.result_out <= WIDTH'(root_fin);
                        bus.rem_out    <= REM_W'(part_rem);
                        bus.err_out    <= 1'b0;
                    end
                    bus.valid_out <= 1'b1;
                    state         <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fx_sqrt_iter.sv
// ============================================================================
// Module      : tb_fx_sqrt_iter
// Description : Directed-vector and model-sweep bench for fx_sqrt_iter variants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fx_sqrt_iter;
    localparam int WIDTH = 32;
    localparam int FRAC  = 11;
    localparam int NV    = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] din;
    logic             vin;
    logic             rin;

    fx_sqrt_iter_if #(.WIDTH(WIDTH)) bus0 ();
    fx_sqrt_iter_if #(.WIDTH(WIDTH)) bus1 ();
    fx_sqrt_iter_if #(.WIDTH(WIDTH)) bus2 ();

    assign bus0.data_in = din;  assign bus0.valid_in = vin;  assign bus0.ready_in = rin;
    assign bus1.data_in = din;  assign bus1.valid_in = vin;  assign bus1.ready_in = rin;
    assign bus2.data_in = din;  assign bus2.valid_in = vin;  assign bus2.ready_in = rin;

    // dut0: floor, 1 bit/cycle; dut1: rounded, 1 bit/cycle; dut2: floor, 2 bits/cycle
    fx_sqrt_iter #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .BPC(1), .ROUND(0)) dut0 (
        .clk_in (clk), .rst_in (rst_n), .bus (bus0.slave));
    fx_sqrt_iter #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .BPC(1), .ROUND(1)) dut1 (
        .clk_in (clk), .rst_in (rst_n), .bus (bus1.slave));
    fx_sqrt_iter #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .BPC(2), .ROUND(0)) dut2 (
        .clk_in (clk), .rst_in (rst_n), .bus (bus2.slave));

    typedef struct {
        logic [31:0] din;
        logic [63:0] res;
        logic [63:0] res_rnd;
        logic [63:0] rem;
        logic        err;
        int          lat0;
        int          lat2;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic with_ready);
        din = x;
        vin = 1'b1;
        rin = with_ready;
        @(posedge clk); #1;
        vin = 1'b0;
        rin = 1'b0;
    endtask

    // Latency is the cycle index of the first valid_out, the transfer cycle being 0.
    task automatic wait_result(output int l0, output int l1, output int l2);
        l0 = -1; l1 = -1; l2 = -1;
        for (int k = 1; k <= 60; k++) begin
            if (bus0.valid_out && l0 < 0) l0 = k;
            if (bus1.valid_out && l1 < 0) l1 = k;
            if (bus2.valid_out && l2 < 0) l2 = k;
            if (l0 >= 0 && l1 >= 0 && l2 >= 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic release_out();
        rin = 1'b1;
        @(posedge clk); #1;
        rin = 1'b0;
        chk("valid_drop", {61'd0, bus0.valid_out, bus1.valid_out, bus2.valid_out}, 64'd0);
    endtask

    function automatic longint isqrt_floor(input longint rr);
        longint r;
        longint t;
        r = 0;
        for (int b = 21; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= rr) r = t;
        end
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running, expected to finish earlier");
        $fatal(1, "time limit");
    end

    initial begin
        int          l0, l1, l2;
        logic [31:0] snap_res;
        logic [32:0] snap_rem;
        logic [31:0] x;
        longint      rr, fr, rnd;
        bit          seen;

        vecs[0]  = '{32'h0000_2000, 4096,    4096,    0,       1'b0, 23, 13};
        vecs[1]  = '{32'h0000_3000, 5016,    5017,    5568,    1'b0, 23, 13};
        vecs[2]  = '{32'h7FFF_FFFF, 2097151, 2097151, 4192255, 1'b0, 23, 13};
        vecs[3]  = '{32'hFFFF_F800, 0,       0,       0,       1'b1, 2,  2};
        vecs[4]  = '{32'h0000_0000, 0,       0,       0,       1'b0, 23, 13};
        vecs[5]  = '{32'h0000_1800, 3547,    3547,    1703,    1'b0, 23, 13};
        vecs[6]  = '{32'h0000_0800, 2048,    2048,    0,       1'b0, 23, 13};
        vecs[7]  = '{32'h0000_0001, 45,      45,      23,      1'b0, 23, 13};
        vecs[8]  = '{32'h0000_0007, 119,     120,     175,     1'b0, 23, 13};
        vecs[9]  = '{32'h8000_0000, 0,       0,       0,       1'b1, 2,  2};
        vecs[10] = '{32'h0000_2800, 4579,    4579,    4279,    1'b0, 23, 13};
        vecs[11] = '{32'h0010_0000, 46340,   46341,   88048,   1'b0, 23, 13};
        vecs[12] = '{32'h0000_0003, 78,      78,      60,      1'b0, 23, 13};

        din = '0; vin = 1'b0; rin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  bus0.ready_out,  1);
        chk("rst_valid",  bus0.valid_out,  0);
        chk("rst_result", bus0.result_out, 0);
        chk("rst_err",    bus0.err_out,    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].din, 1'b0);
            wait_result(l0, l1, l2);
            chk($sformatf("v%0d res_floor", i),  bus0.result_out, vecs[i].res);
            chk($sformatf("v%0d res_round", i),  bus1.result_out, vecs[i].res_rnd);
            chk($sformatf("v%0d res_bpc2", i),   bus2.result_out, vecs[i].res);
            chk($sformatf("v%0d rem_floor", i),  bus0.rem_out,    vecs[i].rem);
            chk($sformatf("v%0d rem_round", i),  bus1.rem_out,    vecs[i].rem);
            chk($sformatf("v%0d err", i),        {bus0.err_out, bus2.err_out}, {vecs[i].err, vecs[i].err});
            chk($sformatf("v%0d lat_bpc1", i),   l0, vecs[i].lat0);
            chk($sformatf("v%0d lat_round", i),  l1, vecs[i].lat0);
            chk($sformatf("v%0d lat_bpc2", i),   l2, vecs[i].lat2);
            release_out();
        end

        // Back-pressure hold followed by a same-cycle release and new accept.
        send(32'h0000_3000, 1'b0);
        wait_result(l0, l1, l2);
        snap_res = bus0.result_out;
        snap_rem = bus0.rem_out;
        chk("bp_first_res", snap_res, 5016);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_res c%0d", c),   bus0.result_out, snap_res);
            chk($sformatf("bp_hold_rem c%0d", c),   bus0.rem_out,    snap_rem);
            chk($sformatf("bp_hold_valid c%0d", c), bus0.valid_out,  1);
            chk($sformatf("bp_ready_low c%0d", c),  bus0.ready_out,  0);
        end
        din = 32'h0000_1800;
        vin = 1'b1;
        rin = 1'b1;
        #1;
        chk("b2b_ready", bus0.ready_out, 1);
        @(posedge clk); #1;
        vin = 1'b0;
        rin = 1'b0;
        chk("b2b_valid_drop", bus0.valid_out, 0);
        wait_result(l0, l1, l2);
        chk("b2b_res",      bus0.result_out, 3547);
        chk("b2b_rem",      bus0.rem_out,    1703);
        chk("b2b_lat_bpc1", l0, 23);
        chk("b2b_lat_bpc2", l2, 13);
        release_out();

        // Asynchronous reset while the previous result is still held on the outputs.
        send(32'h0000_3000, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  bus0.valid_out,  0);
        chk("arst_result", bus0.result_out, 0);
        chk("arst_rem",    bus0.rem_out,    0);
        chk("arst_err",    bus0.err_out,    0);
        chk("arst_ready",  bus0.ready_out,  1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus0.valid_out || bus1.valid_out || bus2.valid_out) seen = 1'b1;
        end
        chk("arst_no_valid", seen, 0);
        chk("arst_ready_after", bus0.ready_out, 1);
        send(32'h0000_2000, 1'b0);
        wait_result(l0, l1, l2);
        chk("arst_recover_res", bus0.result_out, 4096);
        chk("arst_recover_lat", l0, 23);
        release_out();

        // Sweep against an independent bitwise floor-sqrt model.
        for (int n = 0; n < 400; n++) begin
            x = (n % 2 == 0) ? ($urandom & 32'h7FFF_FFFF) : 32'($urandom_range(0, 65535));
            send(x, 1'b0);
            wait_result(l0, l1, l2);
            rr  = longint'(x) << FRAC;
            fr  = isqrt_floor(rr);
            rnd = ((rr - fr * fr) > fr && fr != 64'd2097151) ? fr + 1 : fr;
            chk($sformatf("rnd x=%0d res_floor", x), bus0.result_out, fr);
            chk($sformatf("rnd x=%0d rem_floor", x), bus0.rem_out,    rr - fr * fr);
            chk($sformatf("rnd x=%0d res_round", x), bus1.result_out, rnd);
            chk($sformatf("rnd x=%0d res_bpc2", x),  bus2.result_out, fr);
            release_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
